elevator_scheduler: RTL and testbench



---
 rtl/elevator_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// Single-car elevator sequencer: latches floor calls, serves them in SCAN order,
// and times floor-to-floor travel and door dwell in units of the tick strobe.
module elevator_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FW           = 2,
  parameter int TRAVEL_TICKS = 50,
  parameter int DOOR_TICKS   = 100
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] req_in,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
  } state_t;

  localparam logic [7:0]    TRAVEL_LAST = 8'(TRAVEL_TICKS - 1);
  localparam logic [7:0]    DOOR_LAST   = 8'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);

  state_t                  r_state;
  logic [NUM_FLOORS-1:0]   r_pending;
  logic [FW-1:0]           r_cur_floor;
  logic                    r_dir_up;
  logic                    r_moving;
  logic                    r_door_open;
  logic [7:0]              r_cnt;

  logic [NUM_FLOORS-1:0]   w_req_all;
  logic [NUM_FLOORS-1:0]   w_above;
  logic [NUM_FLOORS-1:0]   w_below;
  logic [NUM_FLOORS-1:0]   w_beyond_up;
  logic [NUM_FLOORS-1:0]   w_beyond_dn;
  logic [NUM_FLOORS-1:0]   w_cur_bit;
  logic [NUM_FLOORS-1:0]   w_up_bit;
  logic [NUM_FLOORS-1:0]   w_dn_bit;
  logic [FW-1:0]           w_floor_up;
  logic [FW-1:0]           w_floor_dn;
  logic                    w_here;
  logic                    w_req_up;
  logic                    w_req_dn;

  // Decisions look at latched calls plus this cycle's pulses.
  assign w_req_all  = r_pending | req_in;
  assign w_floor_up = r_cur_floor + FW'(1);
  assign w_floor_dn = r_cur_floor - FW'(1);

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    localparam logic [FW-1:0] FLOOR_I = FW'(gi);
    assign w_above[gi]     = w_req_all[gi] && (FLOOR_I > r_cur_floor);
    assign w_below[gi]     = w_req_all[gi] && (FLOOR_I < r_cur_floor);
    assign w_beyond_up[gi] = w_req_all[gi] && (FLOOR_I > w_floor_up);
    assign w_beyond_dn[gi] = w_req_all[gi] && (FLOOR_I < w_floor_dn);
    assign w_cur_bit[gi]   = (FLOOR_I == r_cur_floor);
    assign w_up_bit[gi]    = (FLOOR_I == w_floor_up);
    assign w_dn_bit[gi]    = (FLOOR_I == w_floor_dn);
  end

  assign w_here   = |(w_req_all & w_cur_bit);
  assign w_req_up = |(w_req_all & w_up_bit);
  assign w_req_dn = |(w_req_all & w_dn_bit);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_cur_floor <= '0;
      r_dir_up    <= 1'b1;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pending <= w_req_all;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_here) begin
            r_state     <= S_DOOR_OPEN;
            r_door_open <= 1'b1;
            r_pending   <= w_req_all & ~w_cur_bit;
          end else if (|w_above && (r_dir_up || !(|w_below))) begin
            r_state  <= S_MOVE_UP;
            r_moving <= 1'b1;
            r_dir_up <= 1'b1;
          end else if (|w_below) begin
            r_state  <= S_MOVE_DOWN;
            r_moving <= 1'b1;
            r_dir_up <= 1'b0;
          end
        end

        S_MOVE_UP: begin
          if (tick) begin
            if (r_cnt == TRAVEL_LAST) begin
              r_cnt <= '0;
              if (r_cur_floor == TOP_FLOOR) begin
                r_state  <= S_IDLE;
                r_moving <= 1'b0;
              end else begin
                r_cur_floor <= w_floor_up;
                if (w_req_up) begin
                  r_state     <= S_DOOR_OPEN;
                  r_moving    <= 1'b0;
                  r_door_open <= 1'b1;
                  r_pending   <= w_req_all & ~w_up_bit;
                end else if (!(|w_beyond_up)) begin
                  r_state  <= S_IDLE;
                  r_moving <= 1'b0;
                end
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        S_MOVE_DOWN: begin
          if (tick) begin
            if (r_cnt == TRAVEL_LAST) begin
              r_cnt <= '0;
              if (r_cur_floor == '0) begin
                r_state  <= S_IDLE;
                r_moving <= 1'b0;
              end else begin
                r_cur_floor <= w_floor_dn;
                if (w_req_dn) begin
                  r_state     <= S_DOOR_OPEN;
                  r_moving    <= 1'b0;
                  r_door_open <= 1'b1;
                  r_pending   <= w_req_all & ~w_dn_bit;
                end else if (!(|w_beyond_dn)) begin
                  r_state  <= S_IDLE;
                  r_moving <= 1'b0;
                end
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        S_DOOR_OPEN: begin
          // A call to the open floor holds the door rather than queuing a revisit.
          r_pending <= w_req_all & ~w_cur_bit;
          if (|(req_in & w_cur_bit)) begin
            r_cnt <= '0;
          end else if (tick) begin
            if (r_cnt == DOOR_LAST) begin
              r_state     <= S_IDLE;
              r_door_open <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_moving    <= 1'b0;
          r_door_open <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign pending   = r_pending;
  assign cur_floor = r_cur_floor;
  assign dir_up    = r_dir_up;
  assign moving    = r_moving;
  assign door_open = r_door_open;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus a randomized run checked
// against a countdown-based behavioural model of the car.
module tb_elevator_scheduler;

  localparam int NF     = 4;
  localparam int TRAVEL = 2;
  localparam int DOOR   = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          tick;
  logic [NF-1:0] req_in;
  logic [NF-1:0] pending;
  logic [1:0]    cur_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: floor as an integer, trips and dwell as ticks remaining.
  int      m_floor;
  bit [3:0] m_pend;
  bit      m_dir_up;
  int      m_mode;
  int      m_left;

  elevator_scheduler #(
    .NUM_FLOORS  (NF),
    .FW          (2),
    .TRAVEL_TICKS(TRAVEL),
    .DOOR_TICKS  (DOOR)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick     (tick),
    .req_in   (req_in),
    .pending  (pending),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open)
  );

  always #5 clk_in = ~clk_in;

  function automatic bit any_in(bit [3:0] v, int lo, int hi);
    for (int f = lo; f <= hi; f++) begin
      if (f >= 0 && f < NF && v[f]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit [3:0] q);
    bit [3:0] all;
    int nf;
    bit more;
    if (r) begin
      m_floor = 0; m_pend = '0; m_dir_up = 1'b1; m_mode = M_IDLE; m_left = 0;
      return;
    end
    all    = m_pend | q;
    m_pend = all;
    case (m_mode)
      M_IDLE: begin
        if (all[m_floor]) begin
          m_mode = M_DOOR; m_left = DOOR; m_pend[m_floor] = 1'b0;
        end else if (any_in(all, m_floor + 1, NF - 1) &&
                     (m_dir_up || !any_in(all, 0, m_floor - 1))) begin
          m_mode = M_UP; m_dir_up = 1'b1; m_left = TRAVEL;
        end else if (any_in(all, 0, m_floor - 1)) begin
          m_mode = M_DOWN; m_dir_up = 1'b0; m_left = TRAVEL;
        end
      end
      M_UP, M_DOWN: begin
        if (t) begin
          m_left--;
          if (m_left == 0) begin
            nf = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
            if (nf < 0 || nf >= NF) begin
              m_mode = M_IDLE;
            end else begin
              m_floor = nf;
              more = (m_mode == M_UP) ? any_in(all, nf + 1, NF - 1) : any_in(all, 0, nf - 1);
              if (all[nf]) begin
                m_mode = M_DOOR; m_left = DOOR; m_pend[nf] = 1'b0;
              end else if (more) begin
                m_left = TRAVEL;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
        end
      end
      default: begin
        m_pend[m_floor] = 1'b0;
        if (q[m_floor]) begin
          m_left = DOOR;
        end else if (t) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit t, input bit [3:0] q);
    rst = r; tick = t; req_in = q;
    model_step(r, t, q);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 4'b0000);
    n_checks++;
    if ({pending, cur_floor, dir_up, moving, door_open} !== {4'b0000, 2'd0, 3'b100})
      begin n_fail++; $display("FAIL reset_initial: got pend=%b floor=%0d dir=%0d mov=%0d door=%0d, expected 0000/0/1/0/0",
                               pending, cur_floor, dir_up, moving, door_open); end
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    n_checks++;
    if (cur_floor !== 2'd1 || moving !== 1'b1)
      begin n_fail++; $display("FAIL reset_premove: got floor=%0d mov=%0d, expected 1/1", cur_floor, moving); end
    step(1'b1, 1'b1, 4'b0010);
    step(1'b1, 1'b1, 4'b0010);
    n_checks++;
    if (cur_floor !== 2'd0) begin n_fail++; $display("FAIL reset_floor: got %0d expected 0", cur_floor); end
    n_checks++;
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    n_checks++;
    if ({dir_up, moving, door_open} !== 3'b100)
      begin n_fail++; $display("FAIL reset_flags: got dir/mov/door=%b expected 100", {dir_up, moving, door_open}); end
    $display("txn reset: mid-move reset done, floor=%0d", cur_floor);
  endtask

  task automatic test_same_floor();
    int n;
    step(1'b0, 1'b1, 4'b0001);
    n_checks++;
    if (door_open !== 1'b1 || pending !== 4'b0000 || moving !== 1'b0)
      begin n_fail++; $display("FAIL same_floor_open: got door=%0d pend=%b mov=%0d, expected 1/0000/0", door_open, pending, moving); end
    n = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'b0000);
      if (door_open === 1'b1) n++;
      else break;
    end
    n_checks++;
    if (n !== DOOR) begin n_fail++; $display("FAIL same_floor_dwell: got %0d cycles expected %0d", n, DOOR); end
    n_checks++;
    if (door_open !== 1'b0 || moving !== 1'b0)
      begin n_fail++; $display("FAIL same_floor_idle: got door=%0d mov=%0d expected 0/0", door_open, moving); end
    $display("txn same_floor: door open %0d cycles", n);
  endtask

  task automatic test_two_floor();
    step(1'b0, 1'b1, 4'b1000);
    n_checks++;
    if (moving !== 1'b1 || cur_floor !== 2'd0)
      begin n_fail++; $display("FAIL trip_start: got mov=%0d floor=%0d expected 1/0", moving, cur_floor); end
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 4'b0000);
      if (k == 2 || k == 4) begin
        n_checks++;
        if (cur_floor !== 2'(k / 2) || moving !== 1'b1)
          begin n_fail++; $display("FAIL trip_floor_k%0d: got floor=%0d mov=%0d expected %0d/1", k, cur_floor, moving, k / 2); end
      end
      if (k == 5) begin
        n_checks++;
        if (door_open !== 1'b0 || cur_floor !== 2'd2)
          begin n_fail++; $display("FAIL trip_early_door: got door=%0d floor=%0d expected 0/2", door_open, cur_floor); end
      end
      if (k == 6) begin
        n_checks++;
        if (cur_floor !== 2'd3 || door_open !== 1'b1 || moving !== 1'b0 || pending[3] !== 1'b0)
          begin n_fail++; $display("FAIL trip_arrive: got floor=%0d door=%0d mov=%0d pend=%b expected 3/1/0/0xxx",
                                   cur_floor, door_open, moving, pending); end
      end
    end
    for (int i = 0; i < DOOR; i++) step(1'b0, 1'b1, 4'b0000);
    $display("txn two_floor: arrived floor %0d", cur_floor);
  endtask

  task automatic test_scan();
    int order[3];
    int n_open;
    bit prev_door;
    bit dir_at_zero;
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    n_checks++;
    if (cur_floor !== 2'd1 || moving !== 1'b1 || dir_up !== 1'b1)
      begin n_fail++; $display("FAIL scan_setup: got floor=%0d mov=%0d dir=%0d expected 1/1/1", cur_floor, moving, dir_up); end
    step(1'b0, 1'b1, 4'b0101);
    n_open = 0; prev_door = door_open; dir_at_zero = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 4'b0000);
      if (door_open === 1'b1 && !prev_door) begin
        if (n_open < 3) order[n_open] = int'(cur_floor);
        if (cur_floor === 2'd0) dir_at_zero = dir_up;
        n_open++;
      end
      prev_door = door_open;
    end
    n_checks++;
    if (n_open !== 3) begin n_fail++; $display("FAIL scan_stops: got %0d door openings expected 3", n_open); end
    else begin
      n_checks++;
      if (order[0] != 2 || order[1] != 3 || order[2] != 0)
        begin n_fail++; $display("FAIL scan_order: got %0d,%0d,%0d expected 2,3,0", order[0], order[1], order[2]); end
    end
    n_checks++;
    if (dir_at_zero !== 1'b0) begin n_fail++; $display("FAIL scan_reverse: got dir_up=%0d at floor 0 expected 0", dir_at_zero); end
    n_checks++;
    if (pending !== 4'b0000 || moving !== 1'b0)
      begin n_fail++; $display("FAIL scan_done: got pend=%b mov=%0d expected 0000/0", pending, moving); end
    $display("txn scan: %0d stops, final floor %0d", n_open, cur_floor);
  endtask

  task automatic test_door_extend();
    int n;
    step(1'b0, 1'b1, 4'b0100);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 4'b0000);
      if (door_open === 1'b1) break;
    end
    n_checks++;
    if (door_open !== 1'b1 || cur_floor !== 2'd2)
      begin n_fail++; $display("FAIL extend_arrive: got door=%0d floor=%0d expected 1/2", door_open, cur_floor); end
    n = 1;
    step(1'b0, 1'b1, 4'b0000);
    if (door_open === 1'b1) n++;
    step(1'b0, 1'b1, 4'b0100);
    if (door_open === 1'b1) n++;
    n_checks++;
    if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL extend_clear_wins: got pending=%b expected bit2=0", pending); end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 4'b0000);
      if (door_open === 1'b1) n++;
      else break;
    end
    n_checks++;
    if (n !== 2 + DOOR) begin n_fail++; $display("FAIL extend_dwell: got %0d cycles expected %0d", n, 2 + DOOR); end
    $display("txn door_extend: door open %0d cycles at floor %0d", n, cur_floor);
  endtask

  task automatic test_tick_gating();
    step(1'b0, 1'b0, 4'b1000);
    n_checks++;
    if (moving !== 1'b1 || cur_floor !== 2'd2)
      begin n_fail++; $display("FAIL gate_start: got mov=%0d floor=%0d expected 1/2", moving, cur_floor); end
    for (int i = 1; i <= 25; i++) begin
      step(1'b0, (i % 5) == 0, 4'b0000);
      n_checks++;
      if (i < 10) begin
        if (cur_floor !== 2'd2 || moving !== 1'b1 || door_open !== 1'b0)
          begin n_fail++; $display("FAIL gate_travel_c%0d: got floor=%0d mov=%0d door=%0d expected 2/1/0", i, cur_floor, moving, door_open); end
      end else if (i < 25) begin
        if (cur_floor !== 2'd3 || door_open !== 1'b1 || moving !== 1'b0)
          begin n_fail++; $display("FAIL gate_door_c%0d: got floor=%0d door=%0d mov=%0d expected 3/1/0", i, cur_floor, door_open, moving); end
      end else begin
        if (door_open !== 1'b0 || moving !== 1'b0)
          begin n_fail++; $display("FAIL gate_close: got door=%0d mov=%0d expected 0/0", door_open, moving); end
      end
    end
    $display("txn tick_gating: floor %0d after gated trip", cur_floor);
  endtask

  task automatic test_random();
    bit r, t;
    bit [3:0] q;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step(r, t, q);
      if (r || q != 4'b0000)
        $display("txn rand %0d: rst=%0d tick=%0d req=%b floor=%0d pend=%b", i, r, t, q, cur_floor, pending);
      n_checks++;
      if (pending !== m_pend)
        begin n_fail++; $display("FAIL rand_pending c%0d: got %b expected %b", i, pending, m_pend); end
      n_checks++;
      if (cur_floor !== 2'(m_floor))
        begin n_fail++; $display("FAIL rand_floor c%0d: got %0d expected %0d", i, cur_floor, m_floor); end
      n_checks++;
      if ({dir_up, moving, door_open} !== {m_dir_up, (m_mode == M_UP || m_mode == M_DOWN), m_mode == M_DOOR})
        begin n_fail++; $display("FAIL rand_flags c%0d: got dir/mov/door=%b expected %b", i,
                                 {dir_up, moving, door_open},
                                 {m_dir_up, (m_mode == M_UP || m_mode == M_DOWN), m_mode == M_DOOR}); end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; req_in = '0;
    test_reset();
    test_same_floor();
    test_two_floor();
    test_scan();
    test_door_extend();
    test_tick_gating();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
